// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the execute-stage RV32M multiply/divide unit.
package ex_muldiv_pkg;

  // funct3 encodings of the eight M-extension operations
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // One result bit is produced per cycle
  localparam int MulDivIter = 32;

  // Result value whenever no result is being presented
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Divide-class operations all have funct3[2] set
  function automatic logic is_div_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation: takes magnitudes of signed operands
// on the way in and restores the sign of the product/quotient/remainder on
// the way out.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  // Negate when requested, pass through otherwise
  always_comb begin
    val_o = neg_i ? -val_i : val_i;
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit. Operands are latched on start, the
// result is built one bit per cycle over 32 cycles (or produced immediately
// for divide-by-zero and signed overflow), and a one-cycle ready pulse
// presents the result together with the captured destination register.
import ex_muldiv_pkg::*;

module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] reg1_rdata_i,
  input  logic [31:0] reg2_rdata_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        hold_req_o,
  output logic        ready_o,
  output logic [31:0] result_o,
  output logic [4:0]  reg_waddr_o
);

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] opb_q, opb_d;      // multiplicand or divisor magnitude
  logic [63:0] acc_q, acc_d;      // {high/partial remainder, low/multiplier/quotient}
  logic        neg_q, neg_d;      // result must be negated at the end
  logic        ready_q, ready_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  waddr_q, waddr_d;

  // ---------------- start-time operand decode ----------------
  logic        a_signed, b_signed, a_neg, b_neg, neg_start;
  logic [31:0] a_mag, b_mag;
  logic        div_by_zero, div_overflow;
  logic [31:0] special_result;

  // Decide operand signedness, result sign and the special division cases
  always_comb begin
    a_signed     = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                   (op_i == OP_DIV) || (op_i == OP_REM);
    b_signed     = (op_i == OP_MUL) || (op_i == OP_MULH) ||
                   (op_i == OP_DIV) || (op_i == OP_REM);
    a_neg        = a_signed & reg1_rdata_i[31];
    b_neg        = b_signed & reg2_rdata_i[31];
    // Remainder takes the dividend's sign; everything else the XOR of both
    neg_start    = (op_i == OP_REM) ? a_neg : (a_neg ^ b_neg);
    div_by_zero  = is_div_op(op_i) && (reg2_rdata_i == 32'h0);
    div_overflow = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                   (reg1_rdata_i == 32'h8000_0000) && (reg2_rdata_i == 32'hFFFF_FFFF);
    // op[1] distinguishes REM/REMU from DIV/DIVU
    if (div_by_zero) begin
      special_result = op_i[1] ? reg1_rdata_i : 32'hFFFF_FFFF;
    end else begin
      special_result = op_i[1] ? ZeroWord : 32'h8000_0000;
    end
  end

  muldiv_sign_fix #(.W(32)) u_pre_a (
    .val_i (reg1_rdata_i),
    .neg_i (a_neg),
    .val_o (a_mag)
  );

  muldiv_sign_fix #(.W(32)) u_pre_b (
    .val_i (reg2_rdata_i),
    .neg_i (b_neg),
    .val_o (b_mag)
  );

  // ---------------- iteration datapath ----------------
  logic [32:0] mul_sum;
  logic [32:0] div_trial;
  logic [63:0] step_next;
  logic [31:0] div_sel;
  logic [63:0] post_in, post_out;
  logic [31:0] final_result;

  // One shift-add (multiply) or restoring-subtract (divide) step
  always_comb begin
    // Multiply: low half holds the remaining multiplier bits, LSB first
    mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opb_q : 32'h0)};
    // Divide: shift in the next dividend bit, try subtracting the divisor
    div_trial = {acc_q[63:32], acc_q[31]} - {1'b0, opb_q};
    if (is_div_op(op_q)) begin
      step_next = div_trial[32] ? {acc_q[62:0], 1'b0}
                                : {div_trial[31:0], acc_q[30:0], 1'b1};
    end else begin
      step_next = {mul_sum, acc_q[31:1]};
    end
    div_sel = op_q[1] ? step_next[63:32] : step_next[31:0];
    post_in = is_div_op(op_q) ? {32'h0, div_sel} : step_next;
  end

  muldiv_sign_fix #(.W(64)) u_post (
    .val_i (post_in),
    .neg_i (neg_q),
    .val_o (post_out)
  );

  // MUL and all divides return the low word; MULH* return the high word
  always_comb begin
    final_result = (is_div_op(op_q) || (op_q == OP_MUL)) ? post_out[31:0] : post_out[63:32];
  end

  // ---------------- control FSM ----------------
  // Next-state logic: accept start in IDLE, iterate in CALC, flush overrides
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    waddr_d  = waddr_q;
    ready_d  = 1'b0;
    result_d = ZeroWord;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          opb_d   = b_mag;
          acc_d   = {32'h0, a_mag};
          neg_d   = neg_start;
          waddr_d = reg_waddr_i;
          cnt_d   = 6'd0;
          if (div_by_zero || div_overflow) begin
            state_d  = ST_DONE;
            ready_d  = 1'b1;
            result_d = special_result;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = step_next;
        if (cnt_q == 6'(MulDivIter - 1)) begin
          state_d  = ST_DONE;
          ready_d  = 1'b1;
          result_d = final_result;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A flush kills whatever is in flight, including a same-cycle start
    if (flush_i) begin
      state_d  = ST_IDLE;
      cnt_d    = 6'd0;
      ready_d  = 1'b0;
      result_d = ZeroWord;
    end
  end

  // State and datapath registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 6'd0;
      op_q     <= OP_MUL;
      opb_q    <= 32'h0;
      acc_q    <= 64'h0;
      neg_q    <= 1'b0;
      waddr_q  <= 5'd0;
      ready_q  <= 1'b0;
      result_q <= ZeroWord;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      waddr_q  <= waddr_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  // Outputs; hold is released in the ready cycle so writeback and pipeline
  // release coincide
  always_comb begin
    busy_o      = (state_q != ST_IDLE);
    ready_o     = ready_q;
    result_o    = result_q;
    reg_waddr_o = waddr_q;
    hold_req_o  = (start_i & (state_q == ST_IDLE) & ~flush_i) | (busy_o & ~ready_o);
  end

endmodule
